// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-side next-PC generator built around a direct-mapped branch target
// buffer. Each entry holds a valid bit, a tag, a target PC and a 2-bit
// saturating direction counter. The table is looked up combinationally with
// the IF-stage PC and trained by the resolved-branch stream from EX/MEM.
// Saturating counters track resolved branches and mispredictions.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   if_pc        current fetch PC
//   pred_taken   BTB hit and counter MSB set
//   pred_pc      BTB target when pred_taken, else if_pc + 4
//   btb_hit      valid entry with matching tag for if_pc
//   upd_valid    a resolved branch/jump is presented this cycle
//   upd_pc       PC of the resolved branch
//   upd_taken    resolved direction
//   upd_target   resolved target PC (stored verbatim)
//   upd_correct  prediction for this branch was correct
//   branch_cnt   resolved branches, saturating
//   miss_cnt     mispredicted branches, saturating
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 26,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_pc,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_correct,
   output logic              btb_hit,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int ENTRIES = 1 << INDEX_W;

   // Per-entry state
   logic [ENTRIES-1:0] valid_r;
   logic [TAG_W-1:0]   tag_r    [ENTRIES];
   logic [31:0]        target_r [ENTRIES];
   logic [1:0]         ctr_r    [ENTRIES];

   logic [CNT_W-1:0]   branch_cnt_r;
   logic [CNT_W-1:0]   miss_cnt_r;

   // Lookup-side decode
   logic [INDEX_W-1:0] idx_s;
   logic [TAG_W-1:0]   tag_s;
   logic               hit_s;
   logic               taken_s;
   logic [31:0]        next_pc_s;

   // Update-side decode
   logic [INDEX_W-1:0] uidx_s;
   logic [TAG_W-1:0]   utag_s;
   logic               uhit_s;

   // The two byte-offset bits never take part in indexing or tagging.
   logic unused_pc_bits_s;
   assign unused_pc_bits_s = ^{if_pc[1:0], upd_pc[1:0]};

   // 2-bit direction counter, saturating upward at 3.
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      if (c == 2'b11) begin
         ctr_inc = 2'b11;
      end else begin
         ctr_inc = c + 2'b01;
      end
   endfunction

   // 2-bit direction counter, saturating downward at 0.
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      if (c == 2'b00) begin
         ctr_dec = 2'b00;
      end else begin
         ctr_dec = c - 2'b01;
      end
   endfunction

   // Performance counter increment, holding at all-ones.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      if (&c) begin
         cnt_inc = c;
      end else begin
         cnt_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Combinational lookup of the fetch PC against pre-edge table contents.
   always_comb begin
      idx_s     = if_pc[INDEX_W+1:2];
      tag_s     = if_pc[31:INDEX_W+2];
      hit_s     = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
      taken_s   = hit_s && ctr_r[idx_s][1];
      next_pc_s = if_pc + 32'd4;          // wraps at 2^32
      if (taken_s) begin
         pred_pc = target_r[idx_s];
      end else begin
         pred_pc = next_pc_s;
      end
   end

   assign btb_hit    = hit_s;
   assign pred_taken = taken_s;

   // Decode of the resolved-branch PC for training.
   always_comb begin
      uidx_s = upd_pc[INDEX_W+1:2];
      utag_s = upd_pc[31:INDEX_W+2];
      uhit_s = valid_r[uidx_s] && (tag_r[uidx_s] == utag_s);
   end

   // BTB training: strengthen/weaken on hit, allocate on taken miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= 32'd0;
            ctr_r[i]    <= 2'b01;
         end
      end else if (upd_valid) begin
         if (uhit_s) begin
            if (upd_taken) begin
               ctr_r[uidx_s]    <= ctr_inc(ctr_r[uidx_s]);
               target_r[uidx_s] <= upd_target;
            end else begin
               ctr_r[uidx_s]    <= ctr_dec(ctr_r[uidx_s]);
            end
         end else if (upd_taken) begin
            // Allocation evicts whatever currently lives at this index.
            valid_r[uidx_s]  <= 1'b1;
            tag_r[uidx_s]    <= utag_s;
            target_r[uidx_s] <= upd_target;
            ctr_r[uidx_s]    <= 2'b10;
         end else begin
            // Not-taken branches never earn a BTB entry.
            valid_r <= valid_r;
         end
      end else begin
         valid_r <= valid_r;
      end
   end

   // Saturating branch and mispredict counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_r <= {CNT_W{1'b0}};
         miss_cnt_r   <= {CNT_W{1'b0}};
      end else if (upd_valid) begin
         branch_cnt_r <= cnt_inc(branch_cnt_r);
         if (!upd_correct) begin
            miss_cnt_r <= cnt_inc(miss_cnt_r);
         end else begin
            miss_cnt_r <= miss_cnt_r;
         end
      end else begin
         branch_cnt_r <= branch_cnt_r;
         miss_cnt_r   <= miss_cnt_r;
      end
   end

   assign branch_cnt = branch_cnt_r;
   assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed-vector bench for branch_predictor with CNT_W=4. The stimulus
// process drives one cycle at a time and pushes the outputs expected for the
// current (pre-edge) state into a queue; the monitor pops one entry on each
// falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic [31:0]   if_pc;
   logic          pred_taken;
   logic [31:0]   pred_pc;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic          upd_taken;
   logic [31:0]   upd_target;
   logic          upd_correct;
   logic          btb_hit;
   logic [CW-1:0] branch_cnt;
   logic [CW-1:0] miss_cnt;

   typedef struct packed {
      logic          hit;
      logic          taken;
      logic [31:0]   pc;
      logic [CW-1:0] bcnt;
      logic [CW-1:0] mcnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   nb = 0;   // expected branch count
   int   nm = 0;   // expected miss count

   branch_predictor #(.INDEX_W(4), .TAG_W(26), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_pc(pred_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_correct(upd_correct),
      .btb_hit(btb_hit), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compare one queued expectation per falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("btb_hit",    {31'd0, btb_hit},      {31'd0, e.hit});
         chk("pred_taken", {31'd0, pred_taken},   {31'd0, e.taken});
         chk("pred_pc",    pred_pc,               e.pc);
         chk("branch_cnt", {28'd0, branch_cnt},   {28'd0, e.bcnt});
         chk("miss_cnt",   {28'd0, miss_cnt},     {28'd0, e.mcnt});
      end
   end

   task automatic push_exp(input logic h, input logic t, input logic [31:0] p);
      exp_t e;
      e.hit  = h;
      e.taken = t;
      e.pc   = p;
      e.bcnt = nb[CW-1:0];
      e.mcnt = nm[CW-1:0];
      exp_q.push_back(e);
   endtask

   // One cycle: drive inputs, queue pre-edge expectations, advance past edge.
   task automatic cyc(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic uc,
                      input logic eh, input logic et, input logic [31:0] epc);
      if_pc       = pc;
      upd_valid   = uv;
      upd_pc      = upc;
      upd_taken   = ut;
      upd_target  = utgt;
      upd_correct = uc;
      push_exp(eh, et, epc);
      @(posedge clk);
      #1;
      if (uv) begin
         if (nb < 15) nb++;
         if (!uc && nm < 15) nm++;
      end
   endtask

   task automatic idle(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] epc);
      cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eh, et, epc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      if_pc = 32'h100; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
      upd_target = 32'h0; upd_correct = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      idle(32'h100, 1'b0, 1'b0, 32'h104);
      // Cold taken allocate, same-cycle lookup sees old contents
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h104);
      idle(32'h100, 1'b1, 1'b1, 32'h200);
      // Hysteresis: 10 -> 01
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
      idle(32'h100, 1'b1, 1'b0, 32'h104);
      // Two taken: 01 -> 10 -> 11
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h104);
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200);
      idle(32'h100, 1'b1, 1'b1, 32'h200);
      // Four not-taken: 11 -> 10 -> 01 -> 00 -> 00
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200);
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200);
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h104);
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h104);
      idle(32'h100, 1'b1, 1'b0, 32'h104);
      // One taken from 00 gives 01: still not taken
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h104);
      idle(32'h100, 1'b1, 1'b0, 32'h104);
      // Aliasing: 0x140 evicts 0x100
      cyc(32'h100, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h104);
      idle(32'h100, 1'b0, 1'b0, 32'h104);
      idle(32'h140, 1'b1, 1'b1, 32'h300);
      // Miss not-taken for 0x180 leaves 0x140 intact
      cyc(32'h140, 1'b1, 32'h180, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
      idle(32'h140, 1'b1, 1'b1, 32'h300);
      // Low PC bits ignored; misaligned target stored verbatim
      cyc(32'h141, 1'b1, 32'h143, 1'b1, 32'h305, 1'b1, 1'b1, 1'b1, 32'h300);
      idle(32'h142, 1'b1, 1'b1, 32'h305);
      // Fall-through wrap
      idle(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      // Separate index is independent
      cyc(32'h104, 1'b1, 32'h104, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h108);
      idle(32'h104, 1'b1, 1'b1, 32'h400);
      idle(32'h140, 1'b1, 1'b1, 32'h305);
      // Counter saturation
      for (int i = 0; i < 20; i++) begin
         cyc(32'h140, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h305);
      end
      idle(32'h140, 1'b1, 1'b1, 32'h305);

      // Async reset between edges (we are at posedge + 1)
      if_pc = 32'h140;
      upd_valid = 1'b0;
      #1 rst = 1'b1;
      nb = 0; nm = 0;
      #1 push_exp(1'b0, 1'b0, 32'h144);
      @(posedge clk);
      #1 rst = 1'b0;

      // Cold behaviour after reset
      idle(32'h140, 1'b0, 1'b0, 32'h144);
      cyc(32'h140, 1'b1, 32'h140, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h144);
      idle(32'h140, 1'b1, 1'b1, 32'h500);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
